// File: rtl/button_debounce.sv
// Pushbutton debouncer with press/release/long-press pulses.
// Synchronizes the raw pin, filters bounce, drives LED toggle and press counter.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 100000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       level,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       toggle,
    output logic [7:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          active;
    logic          long_done;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;

    // Two-flop synchronizer, reset to the released pin level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign active = sync2 ^ ACTIVE_LOW;

    // Debounce FSM with registered level, pulses, toggle and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            toggle        <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            unique case (state)
                IDLE: begin
                    level <= 1'b0;
                    if (active) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!active) begin
                        state <= IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= PRESSED;
                        level       <= 1'b1;
                        press       <= 1'b1;
                        toggle      <= ~toggle;
                        press_count <= press_count + 8'd1;
                        hold_cnt    <= '0;
                        long_done   <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!active) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DW'(1);
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= HELD;
                        long_press <= 1'b1;
                        long_done  <= 1'b1;
                        hold_cnt   <= hold_cnt + HW'(1);
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                HELD: begin
                    if (!active) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= DW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (active) begin
                        // hold count is kept so a bounce does not restart the long timer
                        state <= long_done ? HELD : PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
